xge_mac_wb_ctrl: RTL and testbench

XGE_MAC_WB_CTRL -- requirements
Module: xge_mac_wb_ctrl

---
 rtl/xge_mac_wb_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_xge_mac_wb_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_mac_wb_ctrl.sv
// Wishbone master sequencer for the XGE MAC: config writes, interrupt-pending reads, host pass-through.
// Latency: a beat is issued one cycle after grant, ends on wb_ack_o or TIMEOUT, then one GAP cycle.
// Backpressure: host_req is a level held until host_ack; cfg_start pulses collapse while pending.
module xge_mac_wb_ctrl #(
  parameter logic [7:0] ADR_CONFIG   = 8'h00,
  parameter logic [7:0] ADR_INT_PEND = 8'h08,
  parameter logic [7:0] ADR_INT_MASK = 8'h10,
  parameter int         TIMEOUT      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_start,
  input  logic [31:0] cfg_data,
  input  logic [31:0] cfg_mask,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_adr,
  input  logic [31:0] host_wdat,
  output logic        host_ack,
  output logic [31:0] host_rdat,
  output logic        host_err,
  output logic        irq_valid,
  output logic [31:0] irq_pending,
  output logic        wb_cyc_i,
  output logic        wb_stb_i,
  output logic        wb_we_i,
  output logic [7:0]  wb_adr_i,
  output logic [31:0] wb_dat_i,
  input  logic [31:0] wb_dat_o,
  input  logic        wb_ack_o,
  input  logic        wb_int_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CFG_WR  = 3'd1,
    MASK_WR = 3'd2,
    INT_RD  = 3'd3,
    HOST    = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        cfg_pend;
  logic        mask_next;   // CFG_WR acked: the GAP leads straight into MASK_WR
  logic        done_pend;   // config sequence finished: report after its final GAP
  logic        done_err;
  logic        host_hold;   // keeps a still-high host_req from re-granting right after host_ack
  logic [7:0]  tmo_cnt;
  logic [2:0]  holdoff;

  logic        cfg_req;
  logic        in_xfer;
  logic        tmo_hit;

  // A pulse arriving in the very cycle config is granted is absorbed by that grant.
  assign cfg_req = cfg_pend | cfg_start;
  assign in_xfer = (state == CFG_WR) || (state == MASK_WR) || (state == INT_RD) || (state == HOST);
  assign tmo_hit = in_xfer && !wb_ack_o && (tmo_cnt == TMO_LAST);

  // Remember config requests until the sequence is actually granted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cfg_pend <= 1'b0;
    end else if (state == IDLE && cfg_req) begin
      cfg_pend <= 1'b0;
    end else begin
      cfg_pend <= cfg_req;
    end
  end

  // Main sequencer: arbitration, single-beat Wishbone cycles, timeout and result pulses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      mask_next   <= 1'b0;
      done_pend   <= 1'b0;
      done_err    <= 1'b0;
      host_hold   <= 1'b0;
      tmo_cnt     <= 8'd0;
      holdoff     <= 3'd0;
      wb_cyc_i    <= 1'b0;
      wb_stb_i    <= 1'b0;
      wb_we_i     <= 1'b0;
      wb_adr_i    <= 8'd0;
      wb_dat_i    <= 32'd0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      host_ack    <= 1'b0;
      host_rdat   <= 32'd0;
      host_err    <= 1'b0;
      irq_valid   <= 1'b0;
      irq_pending <= 32'd0;
    end else begin
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      host_ack    <= 1'b0;
      host_rdat   <= 32'd0;
      host_err    <= 1'b0;
      irq_valid   <= 1'b0;
      irq_pending <= 32'd0;
      host_hold   <= 1'b0;
      if (holdoff != 3'd0) holdoff <= holdoff - 3'd1;

      case (state)
        IDLE: begin
          if (cfg_req) begin
            state    <= CFG_WR;
            wb_cyc_i <= 1'b1;
            wb_stb_i <= 1'b1;
            wb_we_i  <= 1'b1;
            wb_adr_i <= ADR_CONFIG;
            wb_dat_i <= cfg_data;
            tmo_cnt  <= 8'd0;
          end else if (wb_int_o && holdoff == 3'd0) begin
            state    <= INT_RD;
            wb_cyc_i <= 1'b1;
            wb_stb_i <= 1'b1;
            wb_we_i  <= 1'b0;
            wb_adr_i <= ADR_INT_PEND;
            wb_dat_i <= 32'd0;
            tmo_cnt  <= 8'd0;
          end else if (host_req && !host_hold) begin
            state    <= HOST;
            wb_cyc_i <= 1'b1;
            wb_stb_i <= 1'b1;
            wb_we_i  <= host_we;
            wb_adr_i <= host_adr;
            wb_dat_i <= host_we ? host_wdat : 32'd0;
            tmo_cnt  <= 8'd0;
          end
        end

        CFG_WR, MASK_WR, INT_RD, HOST: begin
          if (wb_ack_o || tmo_hit) begin
            state    <= GAP;
            wb_cyc_i <= 1'b0;
            wb_stb_i <= 1'b0;
            wb_we_i  <= 1'b0;
            wb_adr_i <= 8'd0;
            wb_dat_i <= 32'd0;
            tmo_cnt  <= 8'd0;
            if (state == CFG_WR) begin
              if (wb_ack_o) begin
                mask_next <= 1'b1;
              end else begin
                done_pend <= 1'b1;
                done_err  <= 1'b1;
              end
            end else if (state == MASK_WR) begin
              done_pend <= 1'b1;
              done_err  <= !wb_ack_o;
            end else if (state == INT_RD) begin
              holdoff <= 3'd4;
              if (wb_ack_o) begin
                irq_valid   <= 1'b1;
                irq_pending <= wb_dat_o;
              end
            end else begin
              host_ack  <= 1'b1;
              host_err  <= !wb_ack_o;
              host_rdat <= (wb_ack_o && !wb_we_i) ? wb_dat_o : 32'd0;
              host_hold <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        GAP: begin
          host_hold <= host_hold;
          if (mask_next) begin
            mask_next <= 1'b0;
            state     <= MASK_WR;
            wb_cyc_i  <= 1'b1;
            wb_stb_i  <= 1'b1;
            wb_we_i   <= 1'b1;
            wb_adr_i  <= ADR_INT_MASK;
            wb_dat_i  <= cfg_mask;
            tmo_cnt   <= 8'd0;
          end else begin
            state <= IDLE;
            if (done_pend) begin
              cfg_done  <= 1'b1;
              cfg_err   <= done_err;
              done_pend <= 1'b0;
              done_err  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_mac_wb_ctrl.sv
// Scoreboard bench for xge_mac_wb_ctrl: directed scenarios push expected events, a monitor pops them.
// Latency: MAC model acks a configurable number of cycles after stb, or never.
// Backpressure: host requests are held until host_ack, as a real host would.
module tb_xge_mac_wb_ctrl;

  localparam logic [1:0] K_WB   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_IRQ  = 2'd2;
  localparam logic [1:0] K_HOST = 2'd3;
  localparam int NEVER = 255;

  typedef struct packed {
    logic [1:0]  kind;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [7:0]  dur;
    logic        err;
  } ev_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cfg_start;
  logic [31:0] cfg_data, cfg_mask;
  logic        cfg_done, cfg_err;
  logic        host_req, host_we;
  logic [7:0]  host_adr;
  logic [31:0] host_wdat;
  logic        host_ack, host_err;
  logic [31:0] host_rdat;
  logic        irq_valid;
  logic [31:0] irq_pending;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_int_o;

  xge_mac_wb_ctrl dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cfg_start   (cfg_start),
    .cfg_data    (cfg_data),
    .cfg_mask    (cfg_mask),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_adr    (host_adr),
    .host_wdat   (host_wdat),
    .host_ack    (host_ack),
    .host_rdat   (host_rdat),
    .host_err    (host_err),
    .irq_valid   (irq_valid),
    .irq_pending (irq_pending),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_int_o    (wb_int_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  exp_q[$];
  int   ack_lat  = NEVER;
  logic [31:0] pend_val = 32'd0;
  int   irq_seen = 0;
  int   cyc_n    = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic ev_t mk_ev(input logic [1:0] k, input logic we, input logic [7:0] adr,
                                input logic [31:0] dat, input logic [7:0] dur, input logic err);
    ev_t e;
    e.kind = k; e.we = we; e.adr = adr; e.dat = dat; e.dur = dur; e.err = err;
    return e;
  endfunction

  function automatic logic [31:0] mac_rd(input logic [7:0] adr);
    logic [31:0] v;
    v = 32'hA5A5_0000 | {24'd0, adr};
    if (adr == 8'h08) v = pend_val;
    return v;
  endfunction

  // Pop the next expected event and compare; read beats carry no meaningful write data.
  task automatic pop_cmp(input ev_t got, input string name, output ev_t want);
    bit ok;
    if (exp_q.size() == 0) begin
      want = '0;
      chk(1'b0, {name, "_unexpected"}, 64'(got), 64'd0);
    end else begin
      want = exp_q.pop_front();
      ok = (got.kind == want.kind) && (got.we == want.we) && (got.adr == want.adr) &&
           (got.err == want.err) &&
           ((want.kind == K_WB && !want.we) || (got.dat == want.dat));
      chk(ok, name, 64'({got.kind, got.we, got.adr, got.dat, got.err}),
                    64'({want.kind, want.we, want.adr, want.dat, want.err}));
    end
  endtask

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // MAC model: ack after ack_lat cycles of stb, read data from a fixed map.
  int mac_n = 0;
  always @(negedge wb_clk_i) begin
    wb_dat_o = mac_rd(wb_adr_i);
    if (wb_cyc_i && wb_stb_i) begin
      wb_ack_o = (ack_lat != NEVER) && (mac_n == ack_lat);
      mac_n++;
    end else begin
      wb_ack_o = 1'b0;
      mac_n = 0;
    end
  end

  // Monitor: every beat start and every result pulse is matched against the scoreboard.
  logic       stb_q = 1'b0;
  int         dur = 0, dur_exp = 0;
  int         last_fall = -1000, last_int_fall = -1000;
  logic [7:0] cur_adr = 8'd0;
  logic       cur_we = 1'b0;
  always @(negedge wb_clk_i) begin
    ev_t got, want;
    if (wb_stb_i && !stb_q) begin
      got = mk_ev(K_WB, wb_we_i, wb_adr_i, wb_dat_i, 8'd0, 1'b0);
      pop_cmp(got, "wb_beat", want);
      dur_exp = int'(want.dur);
      if (wb_adr_i == 8'h08 && !wb_we_i)
        chk((cyc_n - last_int_fall) >= 4, "int_holdoff", 64'(cyc_n - last_int_fall), 64'd4);
      if (wb_adr_i == 8'h10 && wb_we_i)
        chk((cyc_n - last_fall) == 1, "cfg_gap", 64'(cyc_n - last_fall), 64'd1);
      dur = 0;
      cur_adr = wb_adr_i;
      cur_we = wb_we_i;
    end
    if (wb_stb_i) dur++;
    if (!wb_stb_i && stb_q) begin
      last_fall = cyc_n;
      if (cur_adr == 8'h08 && !cur_we) last_int_fall = cyc_n;
      if (dur_exp != 0) chk(dur == dur_exp, "stb_len", 64'(dur), 64'(dur_exp));
    end
    stb_q = wb_stb_i;
    if (cfg_done) begin
      got = mk_ev(K_DONE, 1'b0, 8'd0, 32'd0, 8'd0, cfg_err);
      pop_cmp(got, "cfg_done", want);
    end
    if (irq_valid) begin
      got = mk_ev(K_IRQ, 1'b0, 8'd0, irq_pending, 8'd0, 1'b0);
      pop_cmp(got, "irq", want);
      irq_seen++;
    end
    if (host_ack) begin
      got = mk_ev(K_HOST, 1'b0, 8'd0, host_rdat, 8'd0, host_err);
      pop_cmp(got, "host_ack", want);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick(10);
  endtask

  task automatic pulse_cfg();
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic host_txn(input logic we, input logic [7:0] adr, input logic [31:0] wd);
    int n = 0;
    host_we = we; host_adr = adr; host_wdat = wd; host_req = 1'b1;
    @(negedge wb_clk_i);
    while (!host_ack && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(host_ack, "host_wait", 64'(host_ack), 64'd1);
    host_req = 1'b0;
  endtask

  task automatic wait_irq(input int target);
    int n = 0;
    while (irq_seen < target && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(irq_seen >= target, "irq_wait", 64'(irq_seen), 64'(target));
  endtask

  initial begin
    wb_rst_i = 1'b1; cfg_start = 1'b0; cfg_data = 32'd0; cfg_mask = 32'd0;
    host_req = 1'b0; host_we = 1'b0; host_adr = 8'd0; host_wdat = 32'd0;
    wb_int_o = 1'b0; wb_ack_o = 1'b0; wb_dat_o = 32'd0;
    tick(3);
    chk({cfg_done, cfg_err, host_ack, host_err, irq_valid, wb_cyc_i, wb_stb_i, wb_we_i,
         host_rdat, irq_pending, wb_adr_i, wb_dat_i} == '0, "reset_outputs",
        64'({wb_cyc_i, wb_stb_i, cfg_done, host_ack, irq_valid}), 64'd0);
    wb_rst_i = 1'b0;
    tick(3);
    chk(!wb_cyc_i && !wb_stb_i, "idle_after_reset", 64'({wb_cyc_i, wb_stb_i}), 64'd0);

    // Config sequence, MAC acks after 2 cycles.
    ack_lat = 2; cfg_data = 32'h1; cfg_mask = 32'hFF;
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h00, 32'h1, 8'd3, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h10, 32'hFF, 8'd3, 1'b0));
    exp_q.push_back(mk_ev(K_DONE, 1'b0, 8'h00, 32'h0, 8'd0, 1'b0));
    pulse_cfg();
    drain(200);

    // Interrupt read with wb_int_o held: second read only after holdoff.
    pend_val = 32'h0000_0004;
    exp_q.push_back(mk_ev(K_WB, 1'b0, 8'h08, 32'h0, 8'd3, 1'b0));
    exp_q.push_back(mk_ev(K_IRQ, 1'b0, 8'h00, 32'h4, 8'd0, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b0, 8'h08, 32'h0, 8'd3, 1'b0));
    exp_q.push_back(mk_ev(K_IRQ, 1'b0, 8'h00, 32'h4, 8'd0, 1'b0));
    wb_int_o = 1'b1;
    wait_irq(2);
    wb_int_o = 1'b0;
    drain(200);

    // Arbitration: config, then interrupt read, then host, all requested together.
    ack_lat = 1; cfg_data = 32'h55; cfg_mask = 32'h0F; pend_val = 32'h8000_0001;
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h00, 32'h55, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h10, 32'h0F, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_DONE, 1'b0, 8'h00, 32'h0, 8'd0, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b0, 8'h08, 32'h0, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_IRQ, 1'b0, 8'h00, 32'h8000_0001, 8'd0, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b0, 8'h30, 32'h0, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_HOST, 1'b0, 8'h00, 32'hA5A5_0030, 8'd0, 1'b0));
    cfg_start = 1'b1;
    wb_int_o = 1'b1;
    fork
      begin tick(1); cfg_start = 1'b0; end
      host_txn(1'b0, 8'h30, 32'h0);
      begin wait_irq(3); wb_int_o = 1'b0; end
    join
    drain(200);

    // Host write (read data must stay 0) then host read.
    ack_lat = 0;
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h24, 32'h1234_5678, 8'd1, 1'b0));
    exp_q.push_back(mk_ev(K_HOST, 1'b0, 8'h00, 32'h0, 8'd0, 1'b0));
    host_txn(1'b1, 8'h24, 32'h1234_5678);
    drain(100);
    ack_lat = 1;
    exp_q.push_back(mk_ev(K_WB, 1'b0, 8'h20, 32'h0, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_HOST, 1'b0, 8'h00, 32'hA5A5_0020, 8'd0, 1'b0));
    host_txn(1'b0, 8'h20, 32'h0);
    drain(100);

    // Host timeout: stb held 16 cycles, error with zero data.
    ack_lat = NEVER;
    exp_q.push_back(mk_ev(K_WB, 1'b0, 8'h0C, 32'h0, 8'd16, 1'b0));
    exp_q.push_back(mk_ev(K_HOST, 1'b0, 8'h00, 32'h0, 8'd0, 1'b1));
    host_txn(1'b0, 8'h0C, 32'h0);
    drain(100);

    // Config timeout: mask write skipped, done with error.
    cfg_data = 32'hDEAD_BEEF; cfg_mask = 32'h3;
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h00, 32'hDEAD_BEEF, 8'd16, 1'b0));
    exp_q.push_back(mk_ev(K_DONE, 1'b0, 8'h00, 32'h0, 8'd0, 1'b1));
    pulse_cfg();
    drain(200);

    // Reset during the mask write: beat dropped, no cfg_done, then a clean rerun.
    ack_lat = 5; cfg_data = 32'h77; cfg_mask = 32'h1F;
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h00, 32'h77, 8'd6, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h10, 32'h1F, 8'd0, 1'b0));
    pulse_cfg();
    begin
      int n = 0;
      while (!(wb_stb_i && wb_adr_i == 8'h10) && n < 200) begin
        @(negedge wb_clk_i);
        n++;
      end
      chk(wb_stb_i && wb_adr_i == 8'h10, "mask_wr_seen", 64'({wb_stb_i, wb_adr_i}), 64'h110);
    end
    tick(2);
    wb_rst_i = 1'b1;
    tick(1);
    chk(!wb_cyc_i && !wb_stb_i, "reset_drops_stb", 64'({wb_cyc_i, wb_stb_i}), 64'd0);
    tick(2);
    wb_rst_i = 1'b0;
    drain(50);
    ack_lat = 1;
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h00, 32'h77, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_WB, 1'b1, 8'h10, 32'h1F, 8'd2, 1'b0));
    exp_q.push_back(mk_ev(K_DONE, 1'b0, 8'h00, 32'h0, 8'd0, 1'b0));
    pulse_cfg();
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
